// File: rtl/ex_seq_ctrl.sv
// EX-stage sequencer: scalar ops complete in one cycle, matrix ops are issued as NGRP lane groups.
// Optional performance counters are built when EX_SEQ_PERF_EN is defined.
module ex_seq_ctrl #(
    parameter  int unsigned LANES         = 16,
    parameter  int unsigned LANES_PER_CYC = 4,
    localparam int unsigned NGRP          = LANES / LANES_PER_CYC,
    localparam int unsigned GW            = (NGRP > 1) ? $clog2(NGRP) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             ID_valid,
    input  logic             ID_multi,
    output logic             ready,
    input  logic             ME_ready,
    output logic             valid,
    output logic             busy,
    output logic [GW-1:0]    grp_idx,
    output logic [LANES-1:0] lane_mask,
    output logic             res_we,
    output logic [NGRP-1:0]  grp_we,
    output logic [31:0]      perf_busy,
    output logic [31:0]      perf_stall
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [LANES-1:0] GRP_ONES = {LANES{1'b1}} >> (LANES - LANES_PER_CYC);
    localparam logic [GW-1:0]    LAST_GRP = GW'(NGRP - 1);

    state_t        state, state_next;
    logic [GW-1:0] grp, grp_next;
    logic          valid_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grp   <= '0;
            valid <= 1'b0;
        end else begin
            state <= state_next;
            grp   <= grp_next;
            valid <= valid_next;
        end
    end

    always_comb begin
        state_next = state;
        grp_next   = grp;
        valid_next = valid;
        ready      = 1'b0;
        res_we     = 1'b0;
        grp_we     = '0;
        lane_mask  = '0;
        if (flush) begin
            state_next = IDLE;
            grp_next   = '0;
            valid_next = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    ready = ME_ready | !valid;
                    if (ID_valid && ready) begin
                        if (ID_multi) begin
                            state_next = BUSY;
                            grp_next   = '0;
                            valid_next = 1'b0;
                        end else begin
                            res_we     = 1'b1;
                            valid_next = 1'b1;
                        end
                    end else begin
                        valid_next = valid & !ME_ready;
                    end
                end
                BUSY: begin
                    lane_mask = GRP_ONES << (grp * LANES_PER_CYC);
                    grp_we    = NGRP'(1) << grp;
                    if (grp == LAST_GRP) begin
                        state_next = IDLE;
                        grp_next   = '0;
                        valid_next = 1'b1;
                    end else begin
                        grp_next = grp + GW'(1);
                    end
                end
            endcase
        end
        // reset outranks flush and suppresses every strobe, including a pending group write
        if (rst) begin
            ready     = 1'b0;
            res_we    = 1'b0;
            grp_we    = '0;
            lane_mask = '0;
        end
    end

    assign busy    = (state == BUSY);
    assign grp_idx = grp;

`ifdef EX_SEQ_PERF_EN
    logic [31:0] busy_cnt, stall_cnt;

    // cleared by reset only; flush leaves the history intact
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (busy)
                busy_cnt <= busy_cnt + 32'd1;
            if (valid && !ME_ready)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign perf_busy  = busy_cnt;
    assign perf_stall = stall_cnt;
`else
    assign perf_busy  = '0;
    assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_ex_seq_ctrl.sv
// Directed self-checking bench for ex_seq_ctrl at default parameters (16 lanes, 4 per cycle).
module tb_ex_seq_ctrl;

`ifdef EX_SEQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, ID_valid, ID_multi, ME_ready;
    logic        ready, valid, busy, res_we;
    logic [1:0]  grp_idx;
    logic [15:0] lane_mask;
    logic [3:0]  grp_we;
    logic [31:0] perf_busy, perf_stall;

    int checks = 0;
    int errors = 0;
    int busy_cycles = 0;
    int stall_cycles = 0;

    ex_seq_ctrl #(.LANES(16), .LANES_PER_CYC(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .ID_valid(ID_valid), .ID_multi(ID_multi),
        .ready(ready), .ME_ready(ME_ready), .valid(valid), .busy(busy), .grp_idx(grp_idx),
        .lane_mask(lane_mask), .res_we(res_we), .grp_we(grp_we),
        .perf_busy(perf_busy), .perf_stall(perf_stall)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; ID_valid = 1'b1; ID_multi = 1'b0; ME_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
            checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
            checks++; if (grp_we !== 4'b0000) begin errors++; $display("FAIL reset_grp_we got %b want 0000", grp_we); end
            checks++; if (res_we !== 1'b0) begin errors++; $display("FAIL reset_res_we got %b want 0", res_we); end
        end
        rst = 1'b0; ID_valid = 1'b0;
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b want 1", ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL release_busy got %b want 0", busy); end
        checks++; if (perf_busy !== 32'd0 || perf_stall !== 32'd0) begin errors++; $display("FAIL reset_perf got %0d/%0d want 0/0", perf_busy, perf_stall); end
        tick();
    endtask

    task automatic test_scalar_stream();
        ID_valid = 1'b1; ID_multi = 1'b0; ME_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (res_we !== 1'b1) begin errors++; $display("FAIL stream_res_we[%0d] got %b want 1", i, res_we); end
            checks++; if (ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got %b want 1", i, ready); end
            checks++; if (valid !== (i != 0)) begin errors++; $display("FAIL stream_valid[%0d] got %b want %b", i, valid, (i != 0)); end
            tick();
        end
        ID_valid = 1'b0;
        #1;
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL stream_last_valid got %b want 1", valid); end
        checks++; if (res_we !== 1'b0) begin errors++; $display("FAIL stream_idle_res_we got %b want 0", res_we); end
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL stream_drain_valid got %b want 0", valid); end
        tick();
    endtask

    task automatic test_m_op();
        logic [3:0]  gwe [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [15:0] lm  [4] = '{16'h000F, 16'h00F0, 16'h0F00, 16'hF000};
        ID_valid = 1'b1; ID_multi = 1'b1; ME_ready = 1'b1;
        #1;
        checks++; if (ready !== 1'b1 || res_we !== 1'b0) begin errors++; $display("FAIL m_accept ready/res_we got %b/%b want 1/0", ready, res_we); end
        tick();
        ID_multi = 1'b0;
        for (int g = 0; g < 4; g++) begin
            #1;
            checks++; if (busy !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL m_busy[%0d] busy/ready got %b/%b want 1/0", g, busy, ready); end
            checks++; if (res_we !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL m_hold[%0d] res_we/valid got %b/%b want 0/0", g, res_we, valid); end
            checks++; if (grp_idx !== 2'(g)) begin errors++; $display("FAIL m_grp_idx[%0d] got %0d want %0d", g, grp_idx, g); end
            checks++; if (grp_we !== gwe[g]) begin errors++; $display("FAIL m_grp_we[%0d] got %b want %b", g, grp_we, gwe[g]); end
            checks++; if (lane_mask !== lm[g]) begin errors++; $display("FAIL m_lane_mask[%0d] got %h want %h", g, lane_mask, lm[g]); end
            tick();
        end
        busy_cycles += 4;
        ID_valid = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || valid !== 1'b1) begin errors++; $display("FAIL m_done busy/valid got %b/%b want 0/1", busy, valid); end
        checks++; if (grp_we !== 4'b0000 || lane_mask !== 16'h0000) begin errors++; $display("FAIL m_done_strobes got %b/%h want 0000/0000", grp_we, lane_mask); end
        checks++; if (perf_busy !== (PERF ? 32'(busy_cycles) : 32'd0)) begin errors++; $display("FAIL m_perf_busy got %0d want %0d", perf_busy, PERF ? busy_cycles : 0); end
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL m_consumed_valid got %b want 0", valid); end
        tick();
    endtask

    task automatic test_backpressure();
        ID_valid = 1'b1; ID_multi = 1'b0; ME_ready = 1'b1;
        tick();
        ME_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ready !== 1'b0 || res_we !== 1'b0) begin errors++; $display("FAIL bp_ready/res_we[%0d] got %b/%b want 0/0", i, ready, res_we); end
            checks++; if (valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b want 1", i, valid); end
            tick();
        end
        stall_cycles += 3;
        checks++; if (perf_stall !== (PERF ? 32'(stall_cycles) : 32'd0)) begin errors++; $display("FAIL bp_perf_stall got %0d want %0d", perf_stall, PERF ? stall_cycles : 0); end
        ME_ready = 1'b1; ID_valid = 1'b0;
        #1;
        checks++; if (ready !== 1'b1 || valid !== 1'b1) begin errors++; $display("FAIL bp_release ready/valid got %b/%b want 1/1", ready, valid); end
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL bp_drain_valid got %b want 0", valid); end
        tick();
    endtask

    task automatic test_flush();
        ID_valid = 1'b1; ID_multi = 1'b1; ME_ready = 1'b1;
        tick();
        ID_valid = 1'b0;
        #1;
        checks++; if (grp_we !== 4'b0001) begin errors++; $display("FAIL fl_first_grp_we got %b want 0001", grp_we); end
        tick();
        flush = 1'b1; ID_valid = 1'b1;
        #1;
        checks++; if (busy !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL fl_cycle busy/ready got %b/%b want 1/0", busy, ready); end
        checks++; if (grp_we !== 4'b0000 || lane_mask !== 16'h0000) begin errors++; $display("FAIL fl_strobes got %b/%h want 0000/0000", grp_we, lane_mask); end
        tick();
        flush = 1'b0; ID_valid = 1'b0;
        busy_cycles += 2;
        #1;
        checks++; if (busy !== 1'b0 || valid !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL fl_after busy/valid/ready got %b%b%b want 001", busy, valid, ready); end
        checks++; if (grp_idx !== 2'd0) begin errors++; $display("FAIL fl_grp_idx got %0d want 0", grp_idx); end
        tick(); tick();
        checks++; if (perf_busy !== (PERF ? 32'(busy_cycles) : 32'd0)) begin errors++; $display("FAIL fl_perf_busy got %0d want %0d", perf_busy, PERF ? busy_cycles : 0); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL fl_no_late_valid got %b want 0", valid); end
        // flush also kills a result that ME has not taken
        ID_valid = 1'b1; ID_multi = 1'b0;
        tick();
        ME_ready = 1'b0; flush = 1'b1;
        #1;
        checks++; if (ready !== 1'b0 || res_we !== 1'b0) begin errors++; $display("FAIL fl_valid ready/res_we got %b/%b want 0/0", ready, res_we); end
        tick();
        stall_cycles += 1;
        flush = 1'b0; ME_ready = 1'b1; ID_valid = 1'b0;
        #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL fl_valid_killed got %b want 0", valid); end
        checks++; if (perf_stall !== (PERF ? 32'(stall_cycles) : 32'd0)) begin errors++; $display("FAIL fl_perf_stall got %0d want %0d", perf_stall, PERF ? stall_cycles : 0); end
        tick();
    endtask

    task automatic test_reset_mid_busy();
        ID_valid = 1'b1; ID_multi = 1'b1; ME_ready = 1'b1;
        tick();
        ID_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        checks++; if (grp_we !== 4'b0000 || lane_mask !== 16'h0000 || ready !== 1'b0) begin errors++; $display("FAIL rb_strobes got %b/%h/%b want 0000/0000/0", grp_we, lane_mask, ready); end
        tick();
        rst = 1'b0;
        busy_cycles = 0; stall_cycles = 0;
        #1;
        checks++; if (busy !== 1'b0 || valid !== 1'b0 || grp_idx !== 2'd0) begin errors++; $display("FAIL rb_state busy/valid/grp got %b/%b/%0d want 0/0/0", busy, valid, grp_idx); end
        checks++; if (perf_busy !== 32'd0 || perf_stall !== 32'd0) begin errors++; $display("FAIL rb_perf got %0d/%0d want 0/0", perf_busy, perf_stall); end
        tick();
    endtask

    initial begin
        test_reset();
        test_scalar_stream();
        test_m_op();
        test_backpressure();
        test_flush();
        test_reset_mid_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
